conv_seq_ctrl: RTL and testbench
================================

# conv_seq_ctrl

Command-driven sequencer for the feature convolution pipeline, sitting between the Xillybus stream FIFOs and the convolution datapath in the `bus_clk` domain. It fetches 8-bit opcodes from the command FIFO and holds word-count registers loaded from the config stream. It meters kernel and feature words from their FIFOs into the datapath, counts result words, and asserts end-of-file on the read stream once a run completes.

## Interface
- `CNT_W`, default 24: width of the word-count registers and counters; config data bits above `CNT_W` are ignored.
- `bus_clk` in 1: sole clock.
- `bus_rst` in 1: reset, asynchronous, active-high.
- `cfg_wren` in 1: config write strobe, one word per cycle.
- `cfg_addr` in 5: config register address.
- `cfg_data` in 32: config write data.
- `cmd_empty` in 1: command FIFO empty.
- `cmd_rden` out 1: command FIFO read; `cmd_data` is valid the cycle after.
- `cmd_data` in 8: opcode.
- `kern_empty` in 1: kernel FIFO empty.
- `kern_rden` out 1: kernel FIFO read.
- `feat_empty` in 1: feature FIFO empty.
- `feat_rden` out 1: feature FIFO read.
- `dp_ready` in 1: datapath can accept a word this cycle.
- `dp_kern_we` out 1: kernel word on the FIFO output is valid for the datapath.
- `dp_feat_we` out 1: feature word on the FIFO output is valid for the datapath.
- `dp_clear` out 1: one-cycle datapath accumulator/pointer clear.
- `res_wr` in 1: datapath pushed one result word into the read FIFO.
- `rd_empty` in 1: read FIFO empty.
- `rd_open` in 1: host has the read stream open.
- `rd_eof` out 1: to the read stream EOF.
- `busy` out 1: state is not IDLE.
- `err` out 1: sticky error flag.

## Operation
- **Config registers** (reset 0):
  - 0 `KERN_WORDS`, 1 `FEAT_WORDS`, 2 `RES_WORDS`.
  - Other addresses are ignored.
  - A write while `busy`=1 is dropped and sets `err`.
- **Opcodes:**
  - 0x00 NOP.
  - 0x01 LOAD_KERNEL.
  - 0x02 RUN.
  - 0x03 CLEAR_ERR: clears `err`.
  - Any other value: sets `err`, otherwise behaves as NOP.
- **States:** IDLE, FETCH, DECODE, LOAD_K, RUN, DRAIN, DONE.
  - **IDLE:** if `cmd_empty`=0, pulse `cmd_rden` and go to FETCH.
  - **FETCH:** wait one cycle, then go to DECODE.
  - **DECODE:**
    - 0x01 → LOAD_K, with `dp_clear` pulsed.
    - 0x02 → RUN, with `dp_clear` pulsed and the result counter cleared.
    - All other opcodes → IDLE.
  - **LOAD_K:**
    - `kern_rden` = `!kern_empty && dp_ready && (issued < KERN_WORDS)`.
    - Go to IDLE when issued == `KERN_WORDS` and the last `dp_kern_we` has been emitted.
    - If `KERN_WORDS`=0, return to IDLE the cycle after DECODE.
  - **RUN:**
    - `feat_rden` follows the same gating as `kern_rden`, against `FEAT_WORDS`.
    - Go to DRAIN after the last `dp_feat_we`.
    - If `FEAT_WORDS`=0, go straight to DRAIN.
  - **DRAIN:** wait until result count == `RES_WORDS` and `rd_empty`=1, then go to DONE.
  - **DONE:**
    - `rd_eof`=1, held while `rd_open`=1.
    - When `rd_open`=0, deassert `rd_eof` and go to IDLE.
- **Counters:**
  - Issue counter is `CNT_W` bits, zeroed on DECODE.
  - Result counter increments on `res_wr` in any state and saturates at all-ones.
  - A result count exceeding `RES_WORDS` in DRAIN sets `err` and forces DONE.

## Timing
- **Reset values:** all outputs 0, state IDLE, registers 0, `err` 0. Reset mid-run abandons the run immediately; FIFO contents are not touched.
- **Command latency:** `cmd_rden` pulses in cycle N, DECODE occurs in N+2, and the first `kern_rden`/`feat_rden` can assert in N+3.
- **Datapath strobes:**
  - `dp_kern_we(t)` = `kern_rden(t-1)`; `dp_feat_we(t)` = `feat_rden(t-1)`. Both are registered, with exactly 1 cycle latency.
  - Throughput is one word per cycle while `dp_ready`=1 and the FIFO is non-empty.
  - `dp_ready` low stalls issue the same cycle; a word already issued still produces its strobe.
- `dp_clear` is a single cycle, coincident with the DECODE→LOAD_K or DECODE→RUN transition.
- **Simultaneous events:**
  - `cfg_wren` in the same cycle as the IDLE→FETCH transition is accepted, since `busy` is still 0 in that cycle.
  - `res_wr` and the DRAIN exit compare in the same cycle use the post-increment count.
- `cmd_rden` never asserts outside IDLE; `kern_rden` and `feat_rden` are never both 1.

## Test plan
- **Kernel load:** write `KERN_WORDS`=9, push 9 kernel words and opcode 0x01 → 9 `dp_kern_we` pulses, back-to-back, starting N+4 after `cmd_rden`; then IDLE.
- **Run with back-pressure:** `FEAT_WORDS`=16, `RES_WORDS`=4, with `dp_ready` toggling every other cycle → exactly 16 `dp_feat_we`; after 4 `res_wr` and `rd_empty`=1, `rd_eof`=1; it clears one cycle after `rd_open` falls.
- **Starved FIFO:** `kern_empty` held high mid-load for 5 cycles → no reads and no strobes during the gap; the load completes with the exact word count.
- **Errors:**
  - `cfg_wren` during RUN → register unchanged, `err`=1.
  - Opcode 0x7F → `err`=1, state returns to IDLE.
  - Opcode 0x03 → `err`=0.
- **Zero counts:** `FEAT_WORDS`=0, `RES_WORDS`=0, opcode 0x02 → no `feat_rden`; DONE with `rd_eof` once `rd_empty`=1.
- **Reset mid-run:** assert `bus_rst` during RUN after 7 of 16 words → all outputs 0 asynchronously, state IDLE, registers 0.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: opcode-driven sequencer for the feature convolution pipeline.
// It fetches opcodes from the command FIFO and meters kernel and feature words
// into the datapath against word-count registers. It counts result words and
// raises read-stream EOF once a run has drained.
module conv_seq_ctrl #(
  parameter int CNT_W = 24
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        cfg_wren,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        cmd_empty,
  output logic        cmd_rden,
  input  logic [7:0]  cmd_data,
  input  logic        kern_empty,
  output logic        kern_rden,
  input  logic        feat_empty,
  output logic        feat_rden,
  input  logic        dp_ready,
  output logic        dp_kern_we,
  output logic        dp_feat_we,
  output logic        dp_clear,
  input  logic        res_wr,
  input  logic        rd_empty,
  input  logic        rd_open,
  output logic        rd_eof,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD_K, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_LOAD_K  = 8'h01;
  localparam logic [7:0] OP_RUN     = 8'h02;
  localparam logic [7:0] OP_CLR_ERR = 8'h03;

  localparam logic [4:0] A_KERN = 5'd0;
  localparam logic [4:0] A_FEAT = 5'd1;
  localparam logic [4:0] A_RES  = 5'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [7:0]       opcode;
  logic [CNT_W-1:0] kern_words, feat_words, res_words;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] res_cnt, res_cnt_inc;
  logic             cfg_ok;
  logic             bad_op, clr_err, clr_res, drain_over;

  // Config data wider than the counters is simply truncated.
  generate
    if (CNT_W < 32) begin : g_cfg_trunc
      logic unused_cfg_hi;
      assign unused_cfg_hi = ^cfg_data[31:CNT_W];
    end
  endgenerate

  assign busy   = (state != S_IDLE);
  assign rd_eof = (state == S_DONE);
  // Writes land only while idle; the IDLE->FETCH cycle still counts as idle.
  assign cfg_ok = cfg_wren && !busy;

  // Result count as it will be after this cycle's res_wr; DRAIN exit uses it.
  assign res_cnt_inc = (res_wr && (res_cnt != CNT_MAX)) ? res_cnt + 1'b1 : res_cnt;

  // State register.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state, FIFO read strobes and one-cycle decode side effects.
  always_comb begin
    state_nxt  = state;
    cmd_rden   = 1'b0;
    kern_rden  = 1'b0;
    feat_rden  = 1'b0;
    dp_clear   = 1'b0;
    bad_op     = 1'b0;
    clr_err    = 1'b0;
    clr_res    = 1'b0;
    drain_over = 1'b0;
    case (state)
      S_IDLE: begin
        // No command is popped while reset is held, so all outputs stay low.
        if (!cmd_empty && !bus_rst) begin
          cmd_rden  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_IDLE;
        case (opcode)
          OP_LOAD_K: begin
            state_nxt = S_LOAD_K;
            dp_clear  = 1'b1;
          end
          OP_RUN: begin
            state_nxt = S_RUN;
            dp_clear  = 1'b1;
            clr_res   = 1'b1;
          end
          OP_CLR_ERR: clr_err = 1'b1;
          OP_NOP:     ;
          default:    bad_op = 1'b1;
        endcase
      end
      S_LOAD_K: begin
        kern_rden = !kern_empty && dp_ready && (issued < kern_words);
        // The last read's strobe goes out the cycle issued reaches the count.
        if (issued == kern_words) state_nxt = S_IDLE;
      end
      S_RUN: begin
        feat_rden = !feat_empty && dp_ready && (issued < feat_words);
        if (issued == feat_words) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_cnt_inc > res_words) begin
          drain_over = 1'b1;
          state_nxt  = S_DONE;
        end else if ((res_cnt_inc == res_words) && rd_empty) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!rd_open) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Opcode is captured in FETCH, the cycle the FIFO presents it.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst)               opcode <= '0;
    else if (state == S_FETCH) opcode <= cmd_data;
  end

  // Word-count registers; writes while busy are dropped.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      kern_words <= '0;
      feat_words <= '0;
      res_words  <= '0;
    end else if (cfg_ok) begin
      case (cfg_addr)
        A_KERN:  kern_words <= cfg_data[CNT_W-1:0];
        A_FEAT:  feat_words <= cfg_data[CNT_W-1:0];
        A_RES:   res_words  <= cfg_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Issue counter: shared by LOAD_K and RUN, restarted on every decode.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst)                    issued <= '0;
    else if (state == S_DECODE)     issued <= '0;
    else if (kern_rden || feat_rden) issued <= issued + 1'b1;
  end

  // Result counter: counts in any state, saturates, restarts on RUN decode.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst)      res_cnt <= '0;
    else if (clr_res) res_cnt <= '0;
    else              res_cnt <= res_cnt_inc;
  end

  // Datapath strobes trail the FIFO read by exactly one cycle.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      dp_kern_we <= 1'b0;
      dp_feat_we <= 1'b0;
    end else begin
      dp_kern_we <= kern_rden;
      dp_feat_we <= feat_rden;
    end
  end

  // Sticky error: set wins over a CLEAR_ERR decoded in the same cycle.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst)                                         err <= 1'b0;
    else if ((cfg_wren && busy) || bad_op || drain_over) err <= 1'b1;
    else if (clr_err)                                    err <= 1'b0;
  end

  a_rden_excl: assert property (@(posedge bus_clk) disable iff (bus_rst)
    !(kern_rden && feat_rden));
  a_cmd_idle: assert property (@(posedge bus_clk) disable iff (bus_rst)
    cmd_rden |-> (state == S_IDLE));

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: FIFO models feed the DUT, and expected datapath words
// are queued when stimulus is issued. A negedge monitor pops the expected words
// and compares them on every strobe.
module tb_conv_seq_ctrl;
  logic        bus_clk = 1'b0;
  logic        bus_rst = 1'b1;
  logic        cfg_wren = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        cmd_empty = 1'b1;
  logic        cmd_rden;
  logic [7:0]  cmd_data = '0;
  logic        kern_empty = 1'b1;
  logic        kern_rden;
  logic        feat_empty = 1'b1;
  logic        feat_rden;
  logic        dp_ready = 1'b1;
  logic        dp_kern_we, dp_feat_we, dp_clear;
  logic        res_wr = 1'b0;
  logic        rd_empty = 1'b1;
  logic        rd_open = 1'b1;
  logic        rd_eof, busy, err;

  conv_seq_ctrl #(.CNT_W(24)) dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst),
    .cfg_wren(cfg_wren), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cmd_empty(cmd_empty), .cmd_rden(cmd_rden), .cmd_data(cmd_data),
    .kern_empty(kern_empty), .kern_rden(kern_rden),
    .feat_empty(feat_empty), .feat_rden(feat_rden),
    .dp_ready(dp_ready), .dp_kern_we(dp_kern_we), .dp_feat_we(dp_feat_we),
    .dp_clear(dp_clear), .res_wr(res_wr), .rd_empty(rd_empty),
    .rd_open(rd_open), .rd_eof(rd_eof), .busy(busy), .err(err)
  );

  always #5 bus_clk = ~bus_clk;

  int checks = 0;
  int fails  = 0;
  logic [7:0]  cq[$];
  logic [31:0] kq[$], fq[$], exp_k[$], exp_f[$];
  logic [31:0] kern_dout = '0, feat_dout = '0, tmp_w;
  logic [7:0]  tmp_c;
  int rdy_mode = 0;
  int cyc = 0, cmd_cyc = 0, first_k = 0, last_k = 0, nk = 0, nf = 0, nclr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void upd_flags();
    cmd_empty  = (cq.size() == 0);
    kern_empty = (kq.size() == 0);
    feat_empty = (fq.size() == 0);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  // FIFO models: read data appears the cycle after the read strobe.
  always @(posedge bus_clk) begin
    if (!bus_rst) begin
      if (cmd_rden && cq.size() > 0)  begin tmp_c = cq.pop_front(); cmd_data  <= tmp_c; end
      if (kern_rden && kq.size() > 0) begin tmp_w = kq.pop_front(); kern_dout <= tmp_w; end
      if (feat_rden && fq.size() > 0) begin tmp_w = fq.pop_front(); feat_dout <= tmp_w; end
    end
    #1;
    upd_flags();
    case (rdy_mode)
      1:       dp_ready = ~dp_ready;
      2:       dp_ready = 1'($urandom_range(0, 1));
      default: dp_ready = 1'b1;
    endcase
  end

  // Monitor: compare each datapath strobe against the scoreboard.
  always @(negedge bus_clk) begin
    cyc++;
    if (cmd_rden) begin
      cmd_cyc = cyc;
      chk("cmd_rden while busy", busy, 0);
    end
    if (kern_rden) chk("kern_rden on empty fifo", kern_empty, 0);
    if (feat_rden) chk("feat_rden on empty fifo", feat_empty, 0);
    if (kern_rden || feat_rden) chk("rden exclusive", kern_rden & feat_rden, 0);
    if (dp_clear) nclr++;
    if (dp_kern_we) begin
      if (nk == 0) first_k = cyc;
      last_k = cyc;
      nk++;
      if (exp_k.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected dp_kern_we: word %0h, none expected", kern_dout);
      end else chk("kern word", kern_dout, exp_k.pop_front());
    end
    if (dp_feat_we) begin
      nf++;
      if (exp_f.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected dp_feat_we: word %0h, none expected", feat_dout);
      end else chk("feat word", feat_dout, exp_f.pop_front());
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_wren = 1'b1; cfg_addr = a; cfg_data = d;
    tick(1);
    cfg_wren = 1'b0;
  endtask

  task automatic push_words(input bit feat, input int n, input bit expect_it);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (feat) begin fq.push_back(w); if (expect_it) exp_f.push_back(w); end
      else      begin kq.push_back(w); if (expect_it) exp_k.push_back(w); end
    end
    upd_flags();
  endtask

  task automatic issue(input logic [7:0] op);
    cq.push_back(op);
    upd_flags();
    tick(1);
    chk("busy after fetch", busy, 1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin tick(1); n++; end
    chk({name, " idle"}, busy, 0);
  endtask

  task automatic wait_cnt(input string name, input bit feat, input int target, input int bound);
    int n = 0;
    while (((feat ? nf : nk) < target) && n < bound) begin tick(1); n++; end
    chk(name, feat ? nf : nk, target);
  endtask

  task automatic wait_eof(input string name, input int bound);
    int n = 0;
    while (!rd_eof && n < bound) begin tick(1); n++; end
    chk(name, rd_eof, 1);
  endtask

  task automatic res_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      res_wr = 1'b1; tick(1); res_wr = 1'b0; tick(1);
    end
  endtask

  task automatic sb_clear();
    exp_k.delete(); exp_f.delete(); kq.delete(); fq.delete();
    upd_flags();
    nk = 0; nf = 0; nclr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, f, r;
    logic [7:0] hi;

    // Reset state
    tick(2);
    chk("rst busy", busy, 0);      chk("rst err", err, 0);
    chk("rst rd_eof", rd_eof, 0);  chk("rst dp_clear", dp_clear, 0);
    chk("rst dp_kern_we", dp_kern_we, 0); chk("rst dp_feat_we", dp_feat_we, 0);
    bus_rst = 1'b0;
    tick(2);

    // Kernel load: upper config bits are ignored, 9 back-to-back strobes at N+4
    sb_clear();
    cfg_write(5'd0, 32'hFF00_0009);
    push_words(0, 9, 1);
    issue(8'h01);
    wait_idle("kload", 60);
    chk("kload strobes", nk, 9);
    chk("kload first latency", first_k - cmd_cyc, 4);
    chk("kload back-to-back", last_k - first_k, 8);
    chk("kload leftover", exp_k.size(), 0);
    chk("kload dp_clear", nclr, 1);

    // Run with back-pressure plus a dropped config write
    sb_clear();
    cfg_write(5'd1, 32'd16);
    cfg_write(5'd2, 32'd4);
    rdy_mode = 1;
    rd_empty = 1'b1; rd_open = 1'b1;
    push_words(1, 16, 1);
    issue(8'h02);
    tick(2);
    cfg_write(5'd0, 32'd5);
    chk("cfg during run err", err, 1);
    wait_cnt("run strobes", 1, 16, 200);
    tick(3);
    chk("run drain busy", busy, 1);
    chk("run drain eof", rd_eof, 0);
    res_pulses(3);
    chk("run eof before last res", rd_eof, 0);
    res_pulses(1);
    chk("run eof", rd_eof, 1);
    rd_open = 1'b0;
    tick(1);
    chk("run eof clears", rd_eof, 0);
    chk("run back idle", busy, 0);
    chk("run leftover", exp_f.size(), 0);
    rd_open = 1'b1; rdy_mode = 0;

    // Clear error
    issue(8'h03);
    wait_idle("clr", 10);
    chk("clr err", err, 0);

    // Starved kernel FIFO: count register must still hold 9
    sb_clear();
    push_words(0, 4, 1);
    issue(8'h01);
    wait_cnt("starve first part", 0, 4, 50);
    tick(5);
    chk("starve no strobes", nk, 4);
    chk("starve still busy", busy, 1);
    push_words(0, 5, 1);
    wait_idle("starve", 50);
    chk("starve total", nk, 9);
    chk("starve leftover", exp_k.size(), 0);

    // Illegal opcode, then clear
    issue(8'h7F);
    wait_idle("badop", 10);
    chk("badop err", err, 1);
    issue(8'h03);
    wait_idle("clr2", 10);
    chk("clr2 err", err, 0);

    // Zero counts: a stray feature word must stay in the FIFO
    sb_clear();
    cfg_write(5'd1, 32'd0);
    cfg_write(5'd2, 32'd0);
    rd_empty = 1'b0;
    push_words(1, 1, 0);
    issue(8'h02);
    tick(6);
    chk("zero waits on rd_empty", busy, 1);
    chk("zero no eof yet", rd_eof, 0);
    chk("zero no feat read", fq.size(), 1);
    rd_empty = 1'b1;
    tick(1);
    chk("zero eof", rd_eof, 1);
    rd_open = 1'b0;
    tick(1);
    chk("zero idle", busy, 0);
    chk("zero strobes", nf, 0);
    rd_open = 1'b1;

    // Result overflow in DRAIN
    sb_clear();
    cfg_write(5'd1, 32'd1);
    cfg_write(5'd2, 32'd2);
    rd_empty = 1'b0;
    push_words(1, 1, 1);
    issue(8'h02);
    wait_cnt("ovf strobes", 1, 1, 50);
    tick(2);
    res_pulses(2);
    chk("ovf waits", rd_eof, 0);
    res_pulses(1);
    chk("ovf err", err, 1);
    chk("ovf eof", rd_eof, 1);
    rd_open = 1'b0; tick(1); rd_open = 1'b1;
    chk("ovf idle", busy, 0);
    issue(8'h03);
    wait_idle("clr3", 10);

    // Randomized loads and runs
    for (int it = 0; it < 6; it++) begin
      sb_clear();
      rdy_mode = 2;
      k = $urandom_range(1, 12);
      hi = 8'($urandom_range(0, 255));
      cfg_write(5'd0, {hi, 24'(k)});
      push_words(0, k, 1);
      issue(8'h01);
      wait_idle("rnd kload", 200);
      chk("rnd kload strobes", nk, k);
      chk("rnd kload leftover", exp_k.size(), 0);
      f = $urandom_range(1, 10);
      r = $urandom_range(0, 3);
      cfg_write(5'd1, 32'(f));
      cfg_write(5'd2, 32'(r));
      rd_empty = 1'b0;
      push_words(1, f, 1);
      issue(8'h02);
      wait_cnt("rnd run strobes", 1, f, 200);
      tick(2);
      res_pulses(r);
      chk("rnd wait rd_empty", rd_eof, 0);
      rd_empty = 1'b1;
      wait_eof("rnd eof", 10);
      rd_open = 1'b0; tick(1); rd_open = 1'b1;
      chk("rnd idle", busy, 0);
      chk("rnd err", err, 0);
    end
    rdy_mode = 0;

    // Reset mid-run after 7 of 16 feature words
    sb_clear();
    cfg_write(5'd1, 32'd16);
    cfg_write(5'd2, 32'd3);
    push_words(1, 16, 1);
    issue(8'h02);
    tick(2);
    cfg_write(5'd2, 32'd9);
    chk("pre-reset err", err, 1);
    cq.push_back(8'h00);
    upd_flags();
    wait_cnt("pre-reset strobes", 1, 7, 50);
    #2 bus_rst = 1'b1;
    #1;
    chk("arst cmd_rden", cmd_rden, 0);   chk("arst kern_rden", kern_rden, 0);
    chk("arst feat_rden", feat_rden, 0); chk("arst dp_kern_we", dp_kern_we, 0);
    chk("arst dp_feat_we", dp_feat_we, 0); chk("arst dp_clear", dp_clear, 0);
    chk("arst rd_eof", rd_eof, 0);       chk("arst busy", busy, 0);
    chk("arst err", err, 0);
    tick(2);
    sb_clear();
    bus_rst = 1'b0;
    tick(4);
    chk("post-reset nop consumed", cq.size(), 0);
    // Registers are zero: no kernel reads, and a run goes straight to DONE
    push_words(0, 2, 0);
    issue(8'h01);
    wait_idle("post-reset kload", 10);
    chk("post-reset no kern read", kq.size(), 2);
    chk("post-reset no kern strobe", nk, 0);
    rd_empty = 1'b1; rd_open = 1'b0;
    issue(8'h02);
    wait_idle("post-reset run", 20);
    chk("post-reset no feat strobe", nf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
